mem_access_ctrl: RTL and testbench

Sequential initiator for the S-Machine data memory: it accepts one load or store command of 1 to 256 consecutive words from the control unit, then sequences the memory's level-sensitive read_write/addr/data pins so that each write is triggered exactly once. It streams read words out to the core. It sits between the control unit or stack engine and the 256 x 16 data memory, and it is the only driver of that memory's inputs.

---
 rtl/mem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Sequential initiator for the 256x16 S-Machine data memory: one load/store command of 1..256 words.
// Latency: load 2 cycles/word + 1 DONE cycle; store 3 cycles/word (4 with verify) + 1 DONE cycle.
// Backpressure: store waits in W_SETUP with wr_ready high until wr_valid; start ignored while busy.
// Optional feature: define MEM_ACCESS_CTRL_WRITE_VERIFY_EN to add a read-back W_VERIFY state and a sticky verify_err.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write_en,
  input  logic [7:0]  base_addr,
  input  logic [7:0]  count,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        verify_err,
  output logic        mem_read_write,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    R_ADDR    = 3'd1,
    R_CAP     = 3'd2,
    W_SETUP   = 3'd3,
    W_STROBE  = 3'd4,
    W_RELEASE = 3'd5,
    DONE      = 3'd7
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    , W_VERIFY = 3'd6
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
  logic        verify_err_q, verify_err_d;
`endif

  // State and datapath registers; reset abandons any command and drops the write strobe at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= 8'd0;
      remaining_q  <= 8'd0;
      wdata_q      <= 16'd0;
      rd_data_q    <= 16'd0;
      rd_valid_q   <= 1'b0;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
      verify_err_q <= verify_err_d;
`endif
    end
  end

  // Next-state and datapath updates; the address only moves in states where the strobe is low.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    verify_err_d = verify_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = count;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
          verify_err_d = 1'b0;
`endif
          state_d     = write_en ? W_SETUP : R_ADDR;
        end
      end
      R_ADDR: state_d = R_CAP;
      R_CAP: begin
        rd_data_d  = mem_data_in;
        rd_valid_d = 1'b1;
        if (remaining_q == 8'd0) begin
          state_d = DONE;
        end else begin
          addr_d      = addr_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
          state_d     = R_ADDR;
        end
      end
      W_SETUP: begin
        if (wr_valid) begin
          wdata_d = wr_data;
          state_d = W_STROBE;
        end
      end
      W_STROBE: state_d = W_RELEASE;
      W_RELEASE: begin
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
        state_d = W_VERIFY;
`else
        if (remaining_q == 8'd0) begin
          state_d = DONE;
        end else begin
          addr_d      = addr_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
          state_d     = W_SETUP;
        end
`endif
      end
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
      W_VERIFY: begin
        if (mem_data_in != wdata_q) verify_err_d = 1'b1;
        if (remaining_q == 8'd0) begin
          state_d = DONE;
        end else begin
          addr_d      = addr_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
          state_d     = W_SETUP;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign wr_ready       = (state_q == W_SETUP);
  assign mem_read_write = (state_q == W_STROBE);
  assign mem_addr       = addr_q;
  assign mem_data_out   = wdata_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
  assign verify_err     = verify_err_q;
`else
  assign verify_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
  localparam int WPW = 4;
`else
  localparam int WPW = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        write_en = 1'b0;
  logic [7:0]  base_addr = 8'd0;
  logic [7:0]  count = 8'd0;
  logic [15:0] wr_data = 16'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        verify_err;
  logic        mem_read_write;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .write_en(write_en),
    .base_addr(base_addr), .count(count), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .verify_err(verify_err), .mem_read_write(mem_read_write),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Level-sensitive memory model: each rising edge of read_write is one write event.
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic        corrupt_en = 1'b0;
  logic [7:0]  wlog_addr [$];
  logic [15:0] wlog_data [$];
  int          addr_glitch = 0;

  assign mem_data_in = (corrupt_en && mem_addr == 8'h20) ? 16'hDEAD : mem[mem_addr];

  always @(posedge mem_read_write) begin
    #1;
    mem[mem_addr] = mem_data_out;
    wlog_addr.push_back(mem_addr);
    wlog_data.push_back(mem_data_out);
  end

  always @(mem_addr) if (mem_read_write) addr_glitch++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one command and checks it against the reference memory and the cycle rules.
  task automatic run_cmd(input bit wr, input logic [7:0] base, input logic [7:0] cnt,
                         input bit fixed, input int stall_idx, input int stall_cyc,
                         input int extra_m, input int exp_cycles, output logic verr_end);
    logic [15:0] dat [$];
    int nwords, idx, stall_left, m, busy_cyc, done_cnt, bad, wlog_start, glitch_start;
    bit acc, last_done, timeout;
    nwords = int'(cnt) + 1;
    for (int k = 0; k < nwords; k++)
      dat.push_back(fixed ? 16'(16'h1111 * (k + 1)) : 16'($urandom));
    wlog_start = wlog_addr.size();
    glitch_start = addr_glitch;
    @(negedge clk);
    start = 1'b1; write_en = wr; base_addr = base; count = cnt; wr_valid = 1'b0;
    m = -1; busy_cyc = 0; done_cnt = 0; bad = 0; idx = 0; stall_left = stall_cyc;
    acc = 1'b0; last_done = 1'b0; timeout = 1'b0;
    forever begin
      @(negedge clk);
      m++;
      start = 1'b0;
      if (m == extra_m) begin
        start = 1'b1; write_en = ~wr; base_addr = 8'($urandom); count = 8'($urandom);
      end
      if (acc) idx++;
      acc = 1'b0;
      if (!busy) break;
      busy_cyc++;
      last_done = done;
      if (done) done_cnt++;
      if (m > 3000) begin timeout = 1'b1; break; end
      if (!wr) begin
        if (rd_valid !== (m >= 2 && m % 2 == 0 && (m - 2) / 2 <= int'(cnt))) bad++;
        if (done && m != 2 + 2 * int'(cnt)) bad++;
        if (wr_ready) bad++;
        if (rd_valid && m >= 2 && m % 2 == 0)
          check("load_data", {16'd0, rd_data}, {16'd0, ref_mem[8'(int'(base) + (m - 2) / 2)]});
        wr_valid = 1'b0;
      end else if (wr_ready && idx < nwords) begin
        if (idx == stall_idx && stall_left > 0) begin
          wr_valid = 1'b0;
          stall_left--;
        end else begin
          wr_valid = 1'b1;
          wr_data = dat[idx];
          acc = 1'b1;
        end
      end else begin
        wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    check("cmd_timeout", {31'd0, timeout}, 32'd0);
    check("busy_cycles", busy_cyc, exp_cycles);
    check("done_pulse", {31'd0, done_cnt == 1 && last_done}, 32'd1);
    check("mem_addr_final", {24'd0, mem_addr}, {24'd0, 8'(int'(base) + int'(cnt))});
    check("addr_stable", addr_glitch - glitch_start, 32'd0);
    if (!wr) begin
      check("load_rdvalid_timing", bad, 32'd0);
      check("load_no_writes", wlog_addr.size() - wlog_start, 32'd0);
    end else begin
      check("write_count", wlog_addr.size() - wlog_start, nwords);
      bad = 0;
      for (int k = 0; k < nwords; k++) begin
        if (wlog_start + k >= wlog_addr.size()) bad++;
        else if (wlog_addr[wlog_start + k] != 8'(int'(base) + k) ||
                 wlog_data[wlog_start + k] != dat[k]) bad++;
        ref_mem[8'(int'(base) + k)] = dat[k];
      end
      check("write_sequence", bad, 32'd0);
    end
    verr_end = verify_err;
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] base;
    logic [7:0] cnt;
    bit         fixed;
    int         stall_idx;
    int         stall_cyc;
    int         extra_m;
    int         exp_cycles;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic verr;
    int   wn;
    int   n, sidx, scyc;
    bit   wr;
    logic [7:0] b, c;

    vecs[0] = '{1'b1, 8'h10, 8'd2, 1'b1, -1, 0, -1, WPW * 3 + 1};
    vecs[1] = '{1'b0, 8'h10, 8'd2, 1'b0, -1, 0, -1, 7};
    vecs[2] = '{1'b1, 8'hFF, 8'd1, 1'b0, -1, 0, -1, WPW * 2 + 1};
    vecs[3] = '{1'b0, 8'hFF, 8'd1, 1'b0, -1, 0, -1, 5};
    vecs[4] = '{1'b1, 8'h40, 8'd2, 1'b0,  1, 4, -1, WPW * 3 + 1 + 4};
    vecs[5] = '{1'b0, 8'h40, 8'd0, 1'b0, -1, 0,  2, 3};
    vecs[6] = '{1'b1, 8'h80, 8'd0, 1'b0, -1, 0, -1, WPW + 1};
    vecs[7] = '{1'b1, 8'h50, 8'd1, 1'b0, -1, 0,  2, WPW * 2 + 1};
    vecs[8] = '{1'b0, 8'h50, 8'd1, 1'b0, -1, 0,  3, 5};

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 257) ^ 16'h5A5A;
      ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
    end

    // Reset state.
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_verify_err", {31'd0, verify_err}, 32'd0);
    check("rst_rw", {31'd0, mem_read_write}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_data_out", {16'd0, mem_data_out}, 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].wr, vecs[i].base, vecs[i].cnt, vecs[i].fixed, vecs[i].stall_idx,
              vecs[i].stall_cyc, vecs[i].extra_m, vecs[i].exp_cycles, verr);
      check("verify_err_clean", {31'd0, verr}, 32'd0);
      @(negedge clk);
      check("idle_after_cmd", {31'd0, busy}, 32'd0);
    end

    // Reset asserted while a write strobe is high.
    @(negedge clk);
    start = 1'b1; write_en = 1'b1; base_addr = 8'h30; count = 8'd3;
    wr_valid = 1'b1; wr_data = 16'hBEEF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mem_read_write && n < 20) begin @(negedge clk); n++; end
    check("strobe_reached", {31'd0, mem_read_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rw", {31'd0, mem_read_write}, 32'd0);
    check("midrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("midrst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("midrst_mem_data_out", {16'd0, mem_data_out}, 32'd0);
    check("midrst_rd_valid_done", {30'd0, rd_valid, done}, 32'd0);
    wn = wlog_addr.size();
    @(negedge clk);
    reset = 1'b0;
    wr_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("no_access_after_reset", wlog_addr.size() - wn, 32'd0);
    check("idle_after_reset", {31'd0, busy}, 32'd0);
    // The abandoned strobe may or may not have landed; take whatever the memory holds.
    ref_mem[8'h30] = mem[8'h30];

`ifdef MEM_ACCESS_CTRL_WRITE_VERIFY_EN
    // Forced bad read-back at 0x20.
    corrupt_en = 1'b1;
    run_cmd(1'b1, 8'h20, 8'd0, 1'b0, -1, 0, -1, WPW + 1, verr);
    check("verify_err_set", {31'd0, verr}, 32'd1);
    corrupt_en = 1'b0;
    @(negedge clk);
    check("verify_err_sticky", {31'd0, verify_err}, 32'd1);
    run_cmd(1'b1, 8'h21, 8'd0, 1'b0, -1, 0, -1, WPW + 1, verr);
    check("verify_err_cleared", {31'd0, verr}, 32'd0);
`endif

    // Randomized commands checked against the reference memory and cycle formula.
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      b = 8'($urandom);
      c = 8'($urandom_range(0, 12));
      sidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(c))) : -1;
      scyc = (sidx >= 0) ? int'($urandom_range(1, 5)) : 0;
      run_cmd(wr, b, c, 1'b0, sidx, scyc, -1,
              wr ? WPW * (int'(c) + 1) + 1 + scyc : 2 * (int'(c) + 1) + 1, verr);
      check("rand_verify_err", {31'd0, verr}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
